// File: rtl/cache_control_nway_pkg.sv
// Shared types for the N-way cache controller.
// Holds the controller state encoding and the way-index type.
package cache_types;

    // Controller states: lookup, dirty victim eviction, line refill, array re-read
    typedef enum logic [1:0] {
        TAG_COMP,
        WRITE_BACK,
        ALLOCATE,
        SETTLE
    } cache_state_t;

    // Widest way index supported (up to 256 ways)
    localparam int WAY_IDX_W = 8;

    typedef logic [WAY_IDX_W-1:0] way_idx_t;

endpackage

// File: rtl/cache_control_nway_plru.sv
// Tree pseudo-LRU helper: victim selection and access update.
// Node i has children 2i+1 / 2i+2; node i is stored at bit WAYS-2-i.
module plru_tree #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_bits,
    input  logic [WAY_W-1:0] access_way,
    input  logic [WAYS-1:0]  valid,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-2:0]  plru_next
);

    localparam int NB = WAYS - 1;
    localparam logic [NB-1:0] ONE = NB'(1);

    // Victim: lowest invalid way, otherwise walk the tree from the root
    always_comb begin : victim_walk
        int node;
        logic found;
        logic [NB-1:0] sh;
        node = 0;
        found = 1'b0;
        sh = '0;
        victim_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !valid[i]) begin
                victim_way = WAY_W'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int l = 0; l < WAY_W; l++) begin
                sh = plru_bits >> (NB - 1 - node);
                node = 2 * node + 1 + (sh[0] ? 1 : 0);
            end
            victim_way = WAY_W'(node - (WAYS - 1));
        end
    end

    // Update: climb from the accessed leaf, pointing each node away from it
    always_comb begin : touch_path
        int n;
        int p;
        logic [NB-1:0] m;
        plru_next = plru_bits;
        n = WAYS - 1 + int'(access_way);
        p = 0;
        m = '0;
        for (int l = 0; l < WAY_W; l++) begin
            p = (n - 1) / 2;
            m = ONE << (NB - 1 - p);
            if (n % 2 == 1) begin
                plru_next = plru_next | m;
            end else begin
                plru_next = plru_next & ~m;
            end
            n = p;
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way write-back, write-allocate cache.
// Sequences hit, dirty eviction, refill and settle between CPU and pmem.
module cache_control_nway
    import cache_types::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WAYS-1:0]  way_hit,
    input  logic [WAYS-1:0]  way_valid,
    input  logic [WAYS-1:0]  way_dirty,
    input  logic [WAYS-2:0]  plru_bits,
    input  logic             pmem_resp,
    output logic [WAYS-1:0]  valid_we,
    output logic [WAYS-1:0]  tag_we,
    output logic [WAYS-1:0]  data_we,
    output logic [WAYS-1:0]  dirty_we,
    output logic             dirty_in,
    output logic             plru_we,
    output logic [WAYS-2:0]  plru_in,
    output logic [WAY_W-1:0] data_sel,
    output logic             dawmux_sel,
    output logic             addrmux_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             mem_resp
);

    cache_state_t     state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             hold_q;

    logic             req, wr, hit, blank;
    logic [WAY_W-1:0] hw, vic_c;
    logic [WAYS-2:0]  plru_upd;
    logic [WAYS-1:0]  vic_oh, hw_oh;

    assign req   = mem_read | mem_write;
    assign wr    = mem_write & ~mem_read;
    assign hit   = |way_hit;
    assign blank = rst | hold_q;
    assign vic_oh = WAYS'(1) << victim_q;
    assign hw_oh  = WAYS'(1) << hw;

    // Lowest-index hit way wins
    always_comb begin
        hw = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) hw = WAY_W'(i);
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_bits  (plru_bits),
        .access_way (hw),
        .valid      (way_valid),
        .victim_way (vic_c),
        .plru_next  (plru_upd)
    );

    // State, frozen victim and the post-reset quiet cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TAG_COMP;
            victim_q <= '0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            hold_q   <= 1'b0;
        end
    end

    // Next state; victim is captured only at the miss decision
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        if (!hold_q) begin
            unique case (state_q)
                TAG_COMP: begin
                    if (req && !hit) begin
                        victim_d = vic_c;
                        if (way_valid[vic_c] && way_dirty[vic_c])
                            state_d = WRITE_BACK;
                        else
                            state_d = ALLOCATE;
                    end
                end
                WRITE_BACK: if (pmem_resp) state_d = ALLOCATE;
                ALLOCATE:   if (pmem_resp) state_d = SETTLE;
                SETTLE:     state_d = TAG_COMP;
                default:    state_d = TAG_COMP;
            endcase
        end
    end

    // Per-state array strobes, mux selects and handshakes
    always_comb begin
        valid_we    = '0;
        tag_we      = '0;
        data_we     = '0;
        dirty_we    = '0;
        dirty_in    = 1'b0;
        plru_we     = 1'b0;
        plru_in     = '0;
        data_sel    = '0;
        dawmux_sel  = 1'b0;
        addrmux_sel = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        mem_resp    = 1'b0;
        if (!blank) begin
            unique case (state_q)
                TAG_COMP: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        data_sel = hw;
                        plru_we  = 1'b1;
                        plru_in  = plru_upd;
                        if (wr) begin
                            data_we  = hw_oh;
                            dirty_we = hw_oh;
                            dirty_in = 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    pmem_write  = 1'b1;
                    addrmux_sel = 1'b1;
                    data_sel    = victim_q;
                end
                ALLOCATE: begin
                    pmem_read  = 1'b1;
                    dawmux_sel = 1'b1;
                    data_we    = vic_oh;
                    tag_we     = vic_oh;
                    valid_we   = vic_oh;
                    dirty_we   = vic_oh;
                end
                SETTLE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// Testbench for cache_control_nway (WAYS=4).
// Directed scenarios followed by random traffic against a reference model.
module tb_cache_control_nway;

    localparam int WAYS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write, pmem_resp;
    logic [3:0] way_hit, way_valid, way_dirty;
    logic [2:0] plru_bits;
    logic [3:0] valid_we, tag_we, data_we, dirty_we;
    logic       dirty_in, plru_we, dawmux_sel, addrmux_sel;
    logic       pmem_read, pmem_write, mem_resp;
    logic [2:0] plru_in;
    logic [1:0] data_sel;
    logic [27:0] obs;

    int passed = 0;
    int total  = 0;

    // Reference model state: 0 lookup, 1 evict, 2 refill, 3 settle
    int m_phase;
    int m_vic;
    bit m_hold;

    always #5 clk = ~clk;

    cache_control_nway #(.WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
        .plru_bits(plru_bits), .pmem_resp(pmem_resp),
        .valid_we(valid_we), .tag_we(tag_we), .data_we(data_we),
        .dirty_we(dirty_we), .dirty_in(dirty_in),
        .plru_we(plru_we), .plru_in(plru_in), .data_sel(data_sel),
        .dawmux_sel(dawmux_sel), .addrmux_sel(addrmux_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .mem_resp(mem_resp)
    );

    assign obs = {valid_we, tag_we, data_we, dirty_we, dirty_in, plru_we,
                  plru_in, data_sel, dawmux_sel, addrmux_sel,
                  pmem_read, pmem_write, mem_resp};

    // Walk root to leaf following the way number's bits, MSB first
    function automatic logic [2:0] ref_touch(logic [2:0] bits, int w);
        logic [2:0] r;
        int node;
        int dir;
        r = bits;
        node = 0;
        for (int l = 0; l < 2; l++) begin
            dir = (w >> (1 - l)) & 1;
            r[2 - node] = (dir == 0);
            node = 2 * node + 1 + dir;
        end
        return r;
    endfunction

    function automatic int ref_victim(logic [3:0] v, logic [2:0] bits);
        int w;
        int node;
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        w = 0;
        node = 0;
        for (int l = 0; l < 2; l++) begin
            w = 2 * w + int'(bits[2 - node]);
            node = 2 * node + 1 + int'(bits[2 - node]);
        end
        return w;
    endfunction

    function automatic logic [27:0] ref_out();
        logic [3:0] vw, tw, dw, yw;
        logic di, pw, dm, am, pr, pwt, mr;
        logic [2:0] pi;
        logic [1:0] ds;
        int h;
        {vw, tw, dw, yw} = '0;
        {di, pw, dm, am, pr, pwt, mr} = '0;
        pi = '0;
        ds = '0;
        h = 0;
        if (!(rst || m_hold)) begin
            case (m_phase)
                0: if ((mem_read || mem_write) && way_hit != 0) begin
                    for (int i = 3; i >= 0; i--) if (way_hit[i]) h = i;
                    mr = 1'b1;
                    ds = 2'(h);
                    pw = 1'b1;
                    pi = ref_touch(plru_bits, h);
                    if (mem_write && !mem_read) begin
                        dw = 4'(1 << h);
                        yw = dw;
                        di = 1'b1;
                    end
                end
                1: begin
                    pwt = 1'b1;
                    am = 1'b1;
                    ds = 2'(m_vic);
                end
                2: begin
                    pr = 1'b1;
                    dm = 1'b1;
                    vw = 4'(1 << m_vic);
                    tw = vw;
                    dw = vw;
                    yw = vw;
                end
                default: ;
            endcase
        end
        return {vw, tw, dw, yw, di, pw, pi, ds, dm, am, pr, pwt, mr};
    endfunction

    function automatic void ref_step();
        int v;
        if (rst) begin
            m_phase = 0;
            m_vic = 0;
            m_hold = 1;
        end else if (m_hold) begin
            m_hold = 0;
        end else begin
            case (m_phase)
                0: if ((mem_read || mem_write) && way_hit == 0) begin
                    v = ref_victim(way_valid, plru_bits);
                    m_vic = v;
                    m_phase = (way_valid[v] && way_dirty[v]) ? 1 : 2;
                end
                1: if (pmem_resp) m_phase = 2;
                2: if (pmem_resp) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; pmem_resp = 0;
        way_hit = 0; way_valid = 4'hF; way_dirty = 0; plru_bits = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; mem_read = 1; way_hit = 4'b0100; pmem_resp = 1;
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL reset_outputs got %h want 0", obs);
        else passed++;
        tick();
        rst = 0;
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL post_reset_quiet got %h want 0", obs);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if (mem_resp !== 1'b1) $display("FAIL first_hit got %b want 1", mem_resp);
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_read_hit();
        apply_reset();
        mem_read = 1; way_hit = 4'b0100; plru_bits = 3'b000;
        @(negedge clk);
        total++;
        if ({mem_resp, data_sel} !== 3'b110)
            $display("FAIL rd_hit_resp_sel got %b want 110", {mem_resp, data_sel});
        else passed++;
        total++;
        if ({plru_we, plru_in} !== 4'b1001)
            $display("FAIL rd_hit_plru got %b want 1001", {plru_we, plru_in});
        else passed++;
        total++;
        if ((valid_we | tag_we | data_we | dirty_we) !== 4'b0)
            $display("FAIL rd_hit_no_write got %b want 0000",
                     valid_we | tag_we | data_we | dirty_we);
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_write_hit();
        mem_write = 1; way_hit = 4'b0010; plru_bits = 3'b000;
        @(negedge clk);
        total++;
        if ({data_we, dirty_we} !== 8'b0010_0010)
            $display("FAIL wr_hit_we got %b want 00100010", {data_we, dirty_we});
        else passed++;
        total++;
        if ({dirty_in, dawmux_sel, mem_resp} !== 3'b101)
            $display("FAIL wr_hit_ctl got %b want 101", {dirty_in, dawmux_sel, mem_resp});
        else passed++;
        total++;
        if (plru_in !== 3'b100) $display("FAIL wr_hit_plru got %b want 100", plru_in);
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_clean_miss();
        mem_read = 1; way_valid = 4'b1011; way_dirty = 4'hF;
        @(negedge clk);
        total++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000)
            $display("FAIL miss_lookup got %b want 000", {mem_resp, pmem_read, pmem_write});
        else passed++;
        tick();
        for (int c = 0; c < 4; c++) begin
            pmem_resp = (c == 3);
            @(negedge clk);
            total++;
            if ({pmem_read, addrmux_sel, dawmux_sel, dirty_in} !== 4'b1010)
                $display("FAIL alloc_ctl c=%0d got %b want 1010", c,
                         {pmem_read, addrmux_sel, dawmux_sel, dirty_in});
            else passed++;
            total++;
            if ({data_we, tag_we, valid_we, dirty_we} !== 16'h4444)
                $display("FAIL alloc_strobes c=%0d got %h want 4444", c,
                         {data_we, tag_we, valid_we, dirty_we});
            else passed++;
            tick();
        end
        pmem_resp = 0; way_hit = 4'b0100; way_valid = 4'hF;
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL settle_idle got %h want 0", obs);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if ({mem_resp, data_sel} !== 3'b110)
            $display("FAIL refill_hit got %b want 110", {mem_resp, data_sel});
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_dirty_miss();
        mem_write = 1; way_dirty = 4'b0001; plru_bits = 3'b000;
        tick();
        for (int c = 0; c < 5; c++) begin
            pmem_resp = (c == 4);
            @(negedge clk);
            total++;
            if ({pmem_write, pmem_read, addrmux_sel, data_sel} !== 5'b10100)
                $display("FAIL wb_ctl c=%0d got %b want 10100", c,
                         {pmem_write, pmem_read, addrmux_sel, data_sel});
            else passed++;
            tick();
        end
        @(negedge clk);
        total++;
        if ({pmem_read, pmem_write, data_we} !== 6'b10_0001)
            $display("FAIL wb_to_alloc got %b want 100001", {pmem_read, pmem_write, data_we});
        else passed++;
        tick();
        way_hit = 4'b0001;
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL held_resp_settle got %h want 0", obs);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if ({mem_resp, data_we, dirty_in} !== 6'b1_0001_1)
            $display("FAIL dirty_refill_hit got %b want 100011", {mem_resp, data_we, dirty_in});
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_mid_miss();
        mem_read = 1; way_dirty = 4'b1000; plru_bits = 3'b101;
        tick();
        @(negedge clk);
        total++;
        if ({pmem_write, data_sel} !== 3'b111)
            $display("FAIL mid_wb_victim got %b want 111", {pmem_write, data_sel});
        else passed++;
        tick();
        way_dirty = 0; way_valid = 0; plru_bits = 0; pmem_resp = 1;
        @(negedge clk);
        total++;
        if ({pmem_write, data_sel} !== 3'b111)
            $display("FAIL mid_wb_frozen got %b want 111", {pmem_write, data_sel});
        else passed++;
        tick();
        mem_read = 0; pmem_resp = 0;
        @(negedge clk);
        total++;
        if ({data_we, mem_resp} !== 5'b1000_0)
            $display("FAIL mid_alloc_drop got %b want 10000", {data_we, mem_resp});
        else passed++;
        tick();
        pmem_resp = 1;
        @(negedge clk);
        total++;
        if ({valid_we, pmem_read} !== 5'b1000_1)
            $display("FAIL mid_alloc_done got %b want 10001", {valid_we, pmem_read});
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL mid_settle got %h want 0", obs);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL mid_no_resp got %h want 0", obs);
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_rst_mid();
        mem_read = 1; way_valid = 4'b0111;
        tick();
        @(negedge clk);
        total++;
        if ({pmem_read, valid_we} !== 5'b1_1000)
            $display("FAIL rst_pre_alloc got %b want 11000", {pmem_read, valid_we});
        else passed++;
        tick();
        rst = 1;
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL rst_drop got %h want 0", obs);
        else passed++;
        tick();
        rst = 0; mem_read = 1; mem_write = 1; way_hit = 4'b0001; way_valid = 4'hF;
        @(negedge clk);
        total++;
        if (obs !== 28'h0) $display("FAIL rst_quiet got %h want 0", obs);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if ({mem_resp, plru_we, pmem_read} !== 3'b110)
            $display("FAIL rw_hit_ctl got %b want 110", {mem_resp, plru_we, pmem_read});
        else passed++;
        total++;
        if ({data_we, dirty_we} !== 8'h00)
            $display("FAIL rw_hit_no_write got %b want 0", {data_we, dirty_we});
        else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst = (c == 0) || ($urandom_range(0, 79) == 0);
            mem_read = ($urandom_range(0, 2) != 0);
            mem_write = ($urandom_range(0, 1) != 0);
            way_hit = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            way_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            way_dirty = 4'($urandom);
            plru_bits = 3'($urandom);
            pmem_resp = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            total++;
            if (obs !== ref_out())
                $display("FAIL random c=%0d got %h want %h", c, obs, ref_out());
            else passed++;
            ref_step();
            tick();
        end
        clear_inputs();
        rst = 0;
    endtask

    initial begin
        m_phase = 0;
        m_vic = 0;
        m_hold = 1;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_mid_miss();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
